// File: rtl/byte_scan_pkg.sv
// byte_scan_pkg: shared state encoding and width helper for the byte scan reader
package byte_scan_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      PRESENT = 3'd2,
      DWELL   = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/byte_scan_reader_sync.sv
// start_sync: 3-flop synchroniser with a single-cycle rising-edge pulse
module start_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_start_pulse
);
   logic [2:0] r_sync;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[1:0], i_start};
   assign o_start_pulse = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/byte_scan_reader.sv
// byte_scan_reader: snapshots mem_data and presents each byte on a valid/ready port with a dwell
module byte_scan_reader import byte_scan_pkg::*; #(
   parameter int NUM_BYTES    = 4,
   parameter int WIDTH        = 8,
   parameter int DWELL_CYCLES = 100000000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           stop,
   input  logic [NUM_BYTES*WIDTH-1:0]     mem_data,
   output logic [WIDTH-1:0]               out_data,
   output logic [clog2(NUM_BYTES)-1:0]    out_sel,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           done
);
   localparam int SW = clog2(NUM_BYTES);
   localparam int CW = clog2(DWELL_CYCLES + 1);
   state_t                     r_state, w_next;
   logic [NUM_BYTES*WIDTH-1:0] r_snap;
   logic [SW-1:0]              r_idx;
   logic [CW-1:0]              r_cnt;
   logic                       w_start_pulse, w_abort, w_last_cnt, w_last_idx;
   start_sync u_sync (
      .clk           (clk),
      .rst           (rst),
      .i_start       (start),
      .o_start_pulse (w_start_pulse)
   );
   assign w_abort    = stop && (r_state != IDLE);
   assign w_last_cnt = r_cnt == CW'(DWELL_CYCLES - 1);
   assign w_last_idx = r_idx == SW'(NUM_BYTES - 1);
   assign done       = r_state == DONE;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start_pulse ? LOAD : IDLE;
         LOAD:    w_next = PRESENT;
         PRESENT: w_next = out_ready ? DWELL : PRESENT;
         DWELL:   w_next = !w_last_cnt ? DWELL : (w_last_idx ? DONE : LOAD);
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_abort) w_next = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_snap    <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (w_abort) begin
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_start_pulse) begin
               r_snap <= mem_data;
               r_idx  <= '0;
               busy   <= 1'b1;
            end
            LOAD: begin
               out_data  <= r_snap[r_idx*WIDTH +: WIDTH];
               out_sel   <= r_idx;
               out_valid <= 1'b1;
            end
            PRESENT: if (out_ready) begin
               out_valid <= 1'b0;
               r_cnt     <= '0;
            end
            DWELL: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last_cnt && !w_last_idx) r_idx <= r_idx + 1'b1;
            end
            DONE: busy <= 1'b0;
            default: ;
         endcase
      end
endmodule

// File: doc/byte_scan_reader.md
Name: byte_scan_reader

Overview:
- Clocked read-side companion to the 4 x 8-bit switch-written latch memory.
- On a start request, snapshots all stored bytes and presents them one at a time, slot 0 to slot NUM_BYTES-1, on a valid/ready output port.
- Each byte is held for a programmable dwell time so a display or serial consumer can show it.
- Sits between the latch array outputs and the LED/display driver.

Parameters:
- NUM_BYTES, 4, number of byte slots scanned; must be >= 2.
- WIDTH, 8, bits per slot.
- DWELL_CYCLES, 100000000, clk cycles each byte is held after handshake; must be >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  asynchronous scan request (button level); synchronised internally.
- stop  input  1  synchronous abort, sampled on clk.
- mem_data  input  NUM_BYTES*WIDTH  stored bytes; slot i = mem_data[i*WIDTH +: WIDTH].
- out_data  output  WIDTH  byte currently presented.
- out_sel  output  clog2(NUM_BYTES)  slot index of out_data.
- out_valid  output  1  out_data valid, awaiting out_ready.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when scan completes.

Behaviour:
- Reset, immediate and asynchronous: state IDLE. out_data=0, out_sel=0, out_valid=0, busy=0, done=0. Snapshot, index, dwell counter and sync flops all 0.
- Start path: s1<=start, s2<=s1, s3<=s2; start_pulse = s2 & ~s3.
  - start rising before edge N gives start_pulse high between edges N+1 and N+2.
  - FSM leaves IDLE at edge N+2.
  - A held start yields exactly one pulse.
- IDLE:
  - busy=0.
  - On start_pulse: snapshot<=mem_data, idx<=0, busy<=1, go LOAD.
- LOAD (1 cycle): out_data<=snapshot slot idx, out_sel<=idx, out_valid<=1, go PRESENT.
- PRESENT:
  - Hold out_data, out_sel and out_valid stable until out_valid&out_ready at an edge.
  - At that edge: out_valid<=0, cnt<=0, go DWELL.
  - out_valid never deasserts without a handshake, except on stop or rst.
- DWELL:
  - cnt increments each cycle; out_data and out_sel stay held.
  - When cnt==DWELL_CYCLES-1: if idx==NUM_BYTES-1 go DONE, else idx<=idx+1 and go LOAD.
  - Byte k+1 appears (out_valid high) exactly DWELL_CYCLES+1 cycles after byte k's handshake edge.
- DONE (1 cycle): done=1, busy<=0, go IDLE. out_data and out_sel keep the last byte.
- stop:
  - In any non-IDLE state, stop=1 at an edge forces IDLE, out_valid<=0, busy<=0, with no done pulse.
  - stop has priority over a handshake in the same cycle.
  - stop in IDLE has no effect.
- start_pulse while busy is ignored and not queued.
- start_pulse and stop in the same IDLE cycle: start wins.
- mem_data changes during a scan have no effect (snapshot only).
- Dwell counter width is clog2(DWELL_CYCLES+1); no wrap occurs because it is cleared on every DWELL entry.
- rst mid-scan aborts immediately to reset values; no done pulse.

Decomposition:
- Shared package byte_scan_pkg holds:
  - state encoding localparams IDLE, LOAD, PRESENT, DWELL, DONE (3-bit);
  - the clog2 helper function.
- One sub-module, start_sync: 3-flop synchroniser plus rising-edge detector with async active-high reset; output start_pulse.
- The FSM, snapshot register and counters stay in byte_scan_reader.

Test Plan (DWELL_CYCLES=4, NUM_BYTES=4):
- mem_data=32'hDDCCBBAA, out_ready tied 1, pulse start for 3 cycles:
  - out_data = AA, BB, CC, DD with out_sel 0..3;
  - each byte valid 1 cycle, consecutive valid rises 6 cycles apart;
  - done pulses once; busy falls with DONE.
- Same data, out_ready held 0 for 10 cycles on byte 1:
  - out_valid=1 and out_data=BB stable throughout;
  - BB handshake on first ready edge; CC appears 5 cycles later.
- Start scan, change mem_data to 32'h11223344 after byte 0:
  - outputs remain AA, BB, CC, DD.
- Assert stop during DWELL of byte 2:
  - next edge gives IDLE, out_valid=0, busy=0, no done;
  - a new start rescans from slot 0.
- Assert rst mid-PRESENT, asynchronously between edges:
  - all outputs 0 immediately; no done.
- Hold start high for 50 cycles:
  - exactly one scan and one done pulse;
  - a second rise after completion starts a second scan.
